muldiv_unit: RTL



---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_operand_prep.sv | 54 +++++
 rtl/muldiv_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit: funct3 codes,
// FSM state encoding and the default-width word constants.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [XLEN_DEFAULT-1:0] WORD_ALL_ONES   = '1;
    localparam logic [XLEN_DEFAULT-1:0] WORD_MIN_SIGNED = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand preparation: signedness decode, magnitude conversion and
// detection of the divide special cases that bypass the iterative datapath.
module muldiv_operand_prep
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic            is_mul,
    output logic            neg1,
    output logic            neg2,
    output logic [XLEN-1:0] mag1,
    output logic [XLEN-1:0] mag2,
    output logic            special,
    output logic [XLEN-1:0] special_result
);

    localparam logic [XLEN-1:0] ALL_ONES   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_SIGNED = {1'b1, {(XLEN-1){1'b0}}};

    logic signed1;
    logic signed2;
    logic is_rem;
    logic div_zero;
    logic div_ovf;

    always_comb begin
        is_mul  = ~funct3[2];
        is_rem  = funct3[2] & funct3[1];
        signed1 = (funct3 == F3_MULH) | (funct3 == F3_MULHSU) |
                  (funct3 == F3_DIV)  | (funct3 == F3_REM);
        signed2 = (funct3 == F3_MULH) | (funct3 == F3_DIV) | (funct3 == F3_REM);

        neg1 = signed1 & operand1[XLEN-1];
        neg2 = signed2 & operand2[XLEN-1];
        mag1 = neg1 ? -operand1 : operand1;
        mag2 = neg2 ? -operand2 : operand2;

        // Only signed divides can overflow; DIVU/REMU of the same bit patterns are ordinary.
        div_zero = funct3[2] & (operand2 == '0);
        div_ovf  = funct3[2] & signed2 & (operand1 == MIN_SIGNED) & (operand2 == ALL_ONES);
        special  = div_zero | div_ovf;

        special_result = '0;
        if (div_zero) begin
            special_result = is_rem ? operand1 : ALL_ONES;
        end else if (div_ovf) begin
            special_result = is_rem ? '0 : MIN_SIGNED;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with pipeline stall, flush abort and special-case bypass.
// Optional build macro MULDIV_FAST_MUL_EN: single-cycle combinational multiplies.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    input  logic            FLUSH,
    output logic [XLEN-1:0] RESULT,
    output logic            BUSY,
    output logic            DONE
);

    localparam int CNT_W = $clog2(XLEN);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     addend_q, addend_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                neg1_q, neg1_d;
    logic                neg2_q, neg2_d;
    logic                special_q, special_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                p_is_mul, p_neg1, p_neg2, p_special;
    logic [XLEN-1:0]     p_mag1, p_mag2, p_special_result;

    muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
        .funct3         (FUNCT3),
        .operand1       (OPERAND1),
        .operand2       (OPERAND2),
        .is_mul         (p_is_mul),
        .neg1           (p_neg1),
        .neg2           (p_neg2),
        .mag1           (p_mag1),
        .mag2           (p_mag2),
        .special        (p_special),
        .special_result (p_special_result)
    );

    logic [XLEN:0]       add_sum;
    logic [XLEN:0]       rem_shift;
    logic                sub_borrow;
    logic [XLEN-1:0]     sub_diff;
    logic [2*XLEN-1:0]   acc_step;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     fix_value;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN+1:0] fast_p;
`endif

    // acc_q holds {high, low}: multiply keeps {partial, multiplier}, divide keeps {remainder, quotient}.
    always_comb begin
        add_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend_q};
        rem_shift  = acc_q[2*XLEN-1:XLEN-1];
        sub_borrow = rem_shift < {1'b0, addend_q};
        sub_diff   = rem_shift[XLEN-1:0] - addend_q;

        if (!funct3_q[2]) begin
            acc_step = {(acc_q[0] ? add_sum : {1'b0, acc_q[2*XLEN-1:XLEN]}), acc_q[XLEN-1:1]};
        end else if (sub_borrow) begin
            acc_step = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            acc_step = {sub_diff, acc_q[XLEN-2:0], 1'b1};
        end

        prod_fix = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
        if (special_q) begin
            fix_value = acc_q[XLEN-1:0];
        end else if (!funct3_q[2]) begin
            fix_value = (funct3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (funct3_q[1]) begin
            fix_value = neg1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        end else begin
            fix_value = (neg1_q ^ neg2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        end

`ifdef MULDIV_FAST_MUL_EN
        fast_a = {p_neg1, OPERAND1};
        fast_b = {p_neg2, OPERAND2};
        fast_p = fast_a * fast_b;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        addend_d  = addend_q;
        funct3_d  = funct3_q;
        neg1_d    = neg1_q;
        neg2_d    = neg2_q;
        special_d = special_q;
        result_d  = result_q;
        BUSY      = 1'b0;
        DONE      = 1'b0;

        case (state_q)
            S_IDLE: begin
                BUSY = START & ~FLUSH & ~RESET;
                if (START && !FLUSH) begin
                    funct3_d  = FUNCT3;
                    neg1_d    = p_neg1;
                    neg2_d    = p_neg2;
                    special_d = p_special;
                    cnt_d     = '0;
                    addend_d  = p_is_mul ? p_mag1 : p_mag2;
                    if (p_special) begin
                        acc_d   = {{XLEN{1'b0}}, p_special_result};
                        state_d = S_FIX;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, (p_is_mul ? p_mag2 : p_mag1)};
                        state_d = S_CALC;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    if (p_is_mul) begin
                        result_d = (FUNCT3 == F3_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                BUSY = 1'b1;
                if (FLUSH) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                BUSY = 1'b1;
                if (FLUSH) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fix_value;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                // The pipeline advances at the end of this cycle, so START is deliberately not sampled here.
                DONE    = ~FLUSH & ~RESET;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            addend_q  <= '0;
            funct3_q  <= '0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            special_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            addend_q  <= addend_d;
            funct3_q  <= funct3_d;
            neg1_q    <= neg1_d;
            neg2_q    <= neg2_d;
            special_q <= special_d;
            result_q  <= result_d;
        end
    end

    assign RESULT = result_q;

endmodule
